// File: rtl/top_level.sv
// -----------------------------------------------------------------------------
// top_level -- single-voice digital waveform generator
//
// A free-running phase accumulator advances by FREQ_INC every clock. Its top
// byte (the phase p) drives four wave shapers: saw, square, triangle, and a
// noise source taken from a free-running 16-bit Galois LFSR. WaveType picks
// one shape, and the result is registered onto Waveform, so there is one
// sample per clock and one clock of latency.
//
// Parameters
//   PHASE_WIDTH  phase accumulator width in bits (>= 9)
//   FREQ_INC     phase increment per clock (sets the pitch)
//   LFSR_SEED    noise LFSR reset value (must be non-zero)
//
// Ports
//   Clock     in   1  system clock; all state updates on the rising edge
//   Reset     in   1  asynchronous, active-low reset
//   WaveType  in   2  shape select: 00 saw, 01 square, 10 triangle, 11 noise
//   Waveform  out  8  registered unsigned sample
// -----------------------------------------------------------------------------
module top_level #(
  parameter int unsigned             PHASE_WIDTH = 16,
  parameter logic [PHASE_WIDTH-1:0]  FREQ_INC    = PHASE_WIDTH'(1024),
  parameter logic [15:0]             LFSR_SEED   = 16'hACE1
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [1:0] WaveType,
  output logic [7:0] Waveform
);

  typedef enum logic [1:0] {
    WAVE_SAW      = 2'b00,
    WAVE_SQUARE   = 2'b01,
    WAVE_TRIANGLE = 2'b10,
    WAVE_NOISE    = 2'b11
  } wave_e;

  // Galois feedback mask for x^16 + x^14 + x^13 + x^11 + 1.
  localparam logic [15:0] LFSR_MASK = 16'hB400;

  logic [PHASE_WIDTH-1:0] acc_q, acc_d;
  logic [15:0]            lfsr_q, lfsr_d;
  logic [7:0]             wave_q, wave_d;

  logic [7:0]             phase;
  logic [7:0]             tri_ramp;
  wave_e                  wave_sel;

  // Top byte of the pre-update accumulator is the phase that is shaped.
  assign phase    = acc_q[PHASE_WIDTH-1 -: 8];
  assign tri_ramp = {phase[6:0], 1'b0};
  assign wave_sel = wave_e'(WaveType);

  // NOTE: every signal written here gets a default before any branch, so no
  // path can leave a value unassigned and infer a latch.
  always_comb begin
    // The sum wraps modulo 2^PHASE_WIDTH; the carry out is dropped on purpose.
    acc_d  = acc_q + FREQ_INC;
    lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_MASK : 16'h0000);

    wave_d = 8'h00;
    unique case (wave_sel)
      WAVE_SAW:      wave_d = phase;
      WAVE_SQUARE:   wave_d = phase[7] ? 8'hFF : 8'h00;
      // Rising half doubles the phase (0..254); the falling half inverts the
      // same ramp (255..1), so the peak and trough each appear once.
      WAVE_TRIANGLE: wave_d = phase[7] ? ~tri_ramp : tri_ramp;
      WAVE_NOISE:    wave_d = lfsr_q[7:0];
      default:       wave_d = 8'h00;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others, which gives the one-clock latency from
  // acc/lfsr/WaveType to Waveform.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      acc_q  <= '0;
      lfsr_q <= LFSR_SEED;
      wave_q <= 8'h00;
    end else begin
      acc_q  <= acc_d;
      lfsr_q <= lfsr_d;
      wave_q <= wave_d;
    end
  end

  assign Waveform = wave_q;

endmodule

// File: tb/tb_top_level.sv
`timescale 1ns/100ps
module tb_top_level;

  logic       Clock;
  logic       Reset;
  logic [1:0] WaveType;
  logic [7:0] Waveform;

  top_level dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .WaveType (WaveType),
    .Waveform (Waveform)
  );

  // 2 ns clock period.
  initial Clock = 1'b0;
  always #1 Clock = ~Clock;

  typedef struct {
    logic [7:0] exp;
    string      name;
  } sb_t;

  sb_t sb[$];

  int n_checks = 0;
  int n_pass   = 0;

  // Reference state: number of accumulator steps since reset, and the LFSR.
  int          m_k    = 0;
  logic [15:0] m_lfsr = 16'hACE1;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %02h, expected %02h at %0t", name, act, exp, $time);
  endtask

  // Expected sample for a given phase step count, computed arithmetically:
  // p = 4*k mod 256 with the default increment.
  function automatic logic [7:0] ref_wave(input logic [1:0] wt, input int k, input logic [15:0] l);
    int q;
    q = (k * 4) % 256;
    case (wt)
      2'b00:   return 8'(q);
      2'b01:   return ((k % 64) < 32) ? 8'h00 : 8'hFF;
      2'b10:   return (q < 128) ? 8'(2 * q) : 8'(511 - 2 * q);
      default: return l[7:0];
    endcase
  endfunction

  // Drive one clock of stimulus on the falling edge and queue the sample the
  // next rising edge must produce, then advance the reference state.
  task automatic step(input logic [1:0] wt, input logic rst, input logic [7:0] exp, input string name);
    sb_t e;
    @(negedge Clock);
    Reset    = rst;
    WaveType = wt;
    e.exp  = exp;
    e.name = name;
    sb.push_back(e);
    if (!rst) begin
      m_k    = 0;
      m_lfsr = 16'hACE1;
    end else begin
      m_k++;
      if (m_lfsr[0]) m_lfsr = (m_lfsr >> 1) ^ 16'hB400;
      else           m_lfsr = m_lfsr >> 1;
    end
  endtask

  task automatic run(input logic [1:0] wt, input int n, input string name);
    for (int i = 0; i < n; i++) step(wt, 1'b1, ref_wave(wt, m_k, m_lfsr), name);
  endtask

  task automatic hold_reset(input int n);
    for (int i = 0; i < n; i++) step(2'b00, 1'b0, 8'h00, "in_reset");
  endtask

  // Monitor: compares one queued expectation per rising edge, away from it.
  initial begin
    sb_t e;
    forever begin
      @(posedge Clock);
      #0.5;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check(e.name, Waveform, e.exp);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    Reset    = 1'b0;
    WaveType = 2'b00;
    #0.5;
    check("reset_async", Waveform, 8'h00);
    hold_reset(3);

    // Saw through one full period and the wrap back to 00.
    for (int i = 0; i <= 64; i++) step(2'b00, 1'b1, 8'((i * 4) % 256), "saw");

    // Square: two periods.
    run(2'b01, 128, "square");

    // Triangle: one full period.
    run(2'b10, 64, "triangle");

    // Noise from reset: first sample is the seed's low byte.
    hold_reset(2);
    step(2'b11, 1'b1, 8'hE1, "noise_first");
    run(2'b11, 1000, "noise");

    // Switch saw -> square at clock 100 (p = 0x90).
    hold_reset(2);
    run(2'b00, 100, "saw_pre_switch");
    step(2'b01, 1'b1, 8'hFF, "switch_square");
    run(2'b01, 40, "square_post_switch");

    // Asynchronous reset mid-period, away from both clock edges.
    hold_reset(2);
    run(2'b00, 21, "saw_pre_reset");
    @(posedge Clock);
    #0.7;
    Reset = 1'b0;
    #0.2;
    check("async_clear", Waveform, 8'h00);
    m_k    = 0;
    m_lfsr = 16'hACE1;
    hold_reset(2);
    for (int i = 0; i <= 64; i++) step(2'b00, 1'b1, 8'((i * 4) % 256), "saw_restart");

    // Let the monitor drain, bounded by a few cycles.
    repeat (3) @(posedge Clock);
    #1;
    n_checks++;
    if (sb.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
